// File: rtl/pckg_parser_pkg.sv
// Shared definitions for the LVDS packet parser: word widths, header base,
// parser state encoding and drop-reason codes.
// Pure declarations, no logic; imported by the parser, its buffer and its interface.
package pckg_parser_pkg;

  localparam int BUFF_SIZE_DEF       = 8;   // data word / FIFO width
  localparam int DATA_BYTES_SIZE_DEF = 10;  // data words per non-empty packet
  localparam int WORD_W              = 24;  // width of a received LVDS word
  localparam int CNT_W               = 4;   // enough for up to 15 data words

  localparam logic [7:0] HDR_BASE = 8'hF0;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_SIZE  = 3'd1,
    ST_DATA  = 3'd2,
    ST_SUM   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_SIZE    = 2'd0,
    ERR_SUM     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_t;

  // Full 24-bit header word: 0x0000F0 with the channel id in the low nibble.
  function automatic logic [WORD_W-1:0] hdr_word(input int channel_id);
    hdr_word = {16'h0000, HDR_BASE | {4'h0, 4'(channel_id)}};
  endfunction

endpackage

// File: rtl/pckg_parser_if.sv
// Parser bus: LVDS receive strobe/word in, downstream FIFO write port and status out.
// master = parser side, slave = environment (receiver, FIFO, status consumer).
// Ports: rx_valid/rx_data/fifo_full toward the parser; wr_en_fifo/dat_to_fifo,
//        pkt_ok/empty_pkt/pkt_err/err_code/busy from the parser.
interface pckg_parser_if
  import pckg_parser_pkg::*;
#(
  parameter int BUFF_SIZE = BUFF_SIZE_DEF
);
  logic                 rx_valid;
  logic [WORD_W-1:0]    rx_data;
  logic                 fifo_full;
  logic                 wr_en_fifo;
  logic [BUFF_SIZE-1:0] dat_to_fifo;
  logic                 pkt_ok;
  logic                 empty_pkt;
  logic                 pkt_err;
  logic [1:0]           err_code;
  logic                 busy;

  modport master (
    input  rx_valid, rx_data, fifo_full,
    output wr_en_fifo, dat_to_fifo, pkt_ok, empty_pkt, pkt_err, err_code, busy
  );

  modport slave (
    output rx_valid, rx_data, fifo_full,
    input  wr_en_fifo, dat_to_fifo, pkt_ok, empty_pkt, pkt_err, err_code, busy
  );
endinterface

// File: rtl/pckg_rx_buf.sv
// Packet payload buffer: DEPTH x WIDTH register file.
// Write is synchronous (one word per clk), read is combinational (0 cycles).
// No backpressure: the parser owns both pointers. Ports: clk, rst, we/waddr/wdata, raddr/rdata.
module pckg_rx_buf
  import pckg_parser_pkg::*;
#(
  parameter int WIDTH = BUFF_SIZE_DEF,
  parameter int DEPTH = DATA_BYTES_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [CNT_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Cleared on reset so the FIFO data output reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pckg_parser.sv
// LVDS packet parser: hunts header, checks size and 24-bit checksum, buffers payload,
// forwards good packets to a FIFO. Latency: 1 cycle from checksum word to first FIFO word.
// Backpressure: flush stalls while fifo_full; words arriving during flush are dropped (OVERRUN).
// Ports: clk, rst (sync, active high), bus (pckg_parser_if.master).
module pckg_parser
  import pckg_parser_pkg::*;
#(
  parameter int BUFF_SIZE       = BUFF_SIZE_DEF,
  parameter int DATA_BYTES_SIZE = DATA_BYTES_SIZE_DEF,
  parameter int CHANNEL_ID      = 2,
  parameter int TIMEOUT         = 255
) (
  input  logic          clk,
  input  logic          rst,
  pckg_parser_if.master bus
);

  localparam int                IDLE_W     = $clog2(TIMEOUT + 1);
  localparam logic [WORD_W-1:0] HDR        = hdr_word(CHANNEL_ID);
  localparam logic [WORD_W-1:0] SIZE_WORD  = WORD_W'(DATA_BYTES_SIZE);
  localparam logic [CNT_W-1:0]  LAST       = CNT_W'(DATA_BYTES_SIZE - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CNT_W-1:0]     rd_ptr, rd_ptr_nxt;
  logic [WORD_W-1:0]    sum, sum_nxt;
  logic [IDLE_W-1:0]    idle, idle_nxt;
  logic                 empty_mode, empty_mode_nxt;
  logic                 ok_nxt, empty_nxt, err_nxt;
  err_t                 code_nxt;
  logic                 pkt_ok_q, empty_pkt_q, pkt_err_q;
  err_t                 err_code_q;
  logic                 buf_we, wr_en, timeout_hit;
  logic [BUFF_SIZE-1:0] data_byte, rd_data;
  logic [WORD_W-1:0]    sum_expect;

  assign data_byte  = bus.rx_data[BUFF_SIZE-1:0];
  assign wr_en      = (state == ST_FLUSH) && !bus.fifo_full;
  assign sum_expect = empty_mode ? '0 : sum;

  // The idle counter holds TIMEOUT-1 in the cycle before expiry; a strobe in that
  // same cycle wins and the word is processed instead.
  assign timeout_hit = (state inside {ST_SIZE, ST_DATA, ST_SUM}) &&
                       !bus.rx_valid && (idle == IDLE_LIMIT);

  pckg_rx_buf #(
    .WIDTH (BUFF_SIZE),
    .DEPTH (DATA_BYTES_SIZE)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (cnt),
    .wdata (data_byte),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    rd_ptr_nxt     = rd_ptr;
    sum_nxt        = sum;
    idle_nxt       = '0;
    empty_mode_nxt = empty_mode;
    ok_nxt         = 1'b0;
    empty_nxt      = 1'b0;
    err_nxt        = 1'b0;
    code_nxt       = ERR_SIZE;
    buf_we         = 1'b0;

    if ((state inside {ST_SIZE, ST_DATA, ST_SUM}) && !bus.rx_valid)
      idle_nxt = idle + 1'b1;

    unique case (state)
      ST_HUNT: begin
        if (bus.rx_valid && bus.rx_data == HDR) state_nxt = ST_SIZE;
      end
      ST_SIZE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == '0) begin
            state_nxt      = ST_SUM;
            empty_mode_nxt = 1'b1;
          end else if (bus.rx_data == SIZE_WORD) begin
            state_nxt      = ST_DATA;
            empty_mode_nxt = 1'b0;
            cnt_nxt        = '0;
            sum_nxt        = '0;
          end else begin
            state_nxt = ST_HUNT;
            err_nxt   = 1'b1;
            code_nxt  = ERR_SIZE;
          end
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          buf_we  = 1'b1;
          sum_nxt = sum + WORD_W'(data_byte);
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = ST_SUM;
        end
      end
      ST_SUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_expect) begin
            if (empty_mode) begin
              empty_nxt = 1'b1;
              state_nxt = ST_HUNT;
            end else begin
              ok_nxt     = 1'b1;
              rd_ptr_nxt = '0;
              state_nxt  = ST_FLUSH;
            end
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_SUM;
            state_nxt = ST_HUNT;
          end
        end
      end
      ST_FLUSH: begin
        if (wr_en) begin
          rd_ptr_nxt = rd_ptr + 1'b1;
          if (rd_ptr == LAST) state_nxt = ST_HUNT;
        end
        // The receiver cannot be stalled, so a word arriving mid-flush is lost.
        if (bus.rx_valid) begin
          err_nxt  = 1'b1;
          code_nxt = ERR_OVERRUN;
        end
      end
      default: state_nxt = ST_HUNT;
    endcase

    if (timeout_hit) begin
      state_nxt = ST_HUNT;
      err_nxt   = 1'b1;
      code_nxt  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rd_ptr      <= '0;
      sum         <= '0;
      idle        <= '0;
      empty_mode  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      empty_pkt_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_SIZE;
    end else begin
      cnt         <= cnt_nxt;
      rd_ptr      <= rd_ptr_nxt;
      sum         <= sum_nxt;
      idle        <= idle_nxt;
      empty_mode  <= empty_mode_nxt;
      pkt_ok_q    <= ok_nxt;
      empty_pkt_q <= empty_nxt;
      pkt_err_q   <= err_nxt;
      err_code_q  <= code_nxt;
    end
  end

  assign bus.wr_en_fifo  = wr_en;
  assign bus.dat_to_fifo = rd_data;
  assign bus.pkt_ok      = pkt_ok_q;
  assign bus.empty_pkt   = empty_pkt_q;
  assign bus.pkt_err     = pkt_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = (state != ST_HUNT);

endmodule
